sabr_udiv_seq: RTL and testbench

Sequential unsigned integer divider for the SABR HLS datapath: 79-bit dividend by 36-bit divisor, producing a 43-bit quotient and a 36-bit remainder. It is the inverse of the 43x36 to 79 pipelined multiplier used for fixed-point scaling. It restores fixed-point operands after a wide product, for example normalisation of accumulated path sums. It uses radix-2 restoring division with a valid/ready handshake on both sides and honours the same `ce` stall convention as the arithmetic cores.

---
 rtl/sabr_udiv_seq.sv | 143 ++++++++++++++
 tb/tb_sabr_udiv_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sabr_udiv_seq.sv
// sabr_udiv_seq: radix-2 restoring unsigned divider (N-bit dividend / D-bit divisor).
// Valid/ready handshake on both sides; ce low freezes every register.
module sabr_udiv_seq #(
    parameter int ID             = 1,
    parameter int DIVIDEND_WIDTH = 79,
    parameter int DIVISOR_WIDTH  = 36,
    parameter int QUOTIENT_WIDTH = 43
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);
    localparam int N  = DIVIDEND_WIDTH;
    localparam int D  = DIVISOR_WIDTH;
    localparam int Q  = QUOTIENT_WIDTH;
    localparam int CW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] LAST = CW'(Q - 1);

    if (QUOTIENT_WIDTH != DIVIDEND_WIDTH - DIVISOR_WIDTH || ID < 0) begin : g_bad_params
        $error("sabr_udiv_seq: QUOTIENT_WIDTH must equal DIVIDEND_WIDTH - DIVISOR_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  divisor_q;
    logic [D-1:0]  rem_q;
    logic [Q-1:0]  shreg;
    logic [CW-1:0] cnt;

    logic [D-1:0]  hi;
    logic          zero_div, too_big;
    logic [D:0]    trial;
    logic [D-1:0]  diff;
    logic          ge;
    logic [D-1:0]  rem_next;
    logic [Q-1:0]  shift_next;

    assign hi       = dividend[N-1:Q];
    assign zero_div = (divisor == '0);
    assign too_big  = (hi >= divisor);

    // shreg shifts dividend bits out of the top while quotient bits enter at the
    // bottom, so after Q iterations it holds the full quotient.
    always_comb begin
        trial      = {rem_q, shreg[Q-1]};
        ge         = (trial >= {1'b0, divisor_q});
        diff       = trial[D-1:0] - divisor_q;
        rem_next   = ge ? diff : trial[D-1:0];
        shift_next = {shreg[Q-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (zero_div || too_big) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor_q   <= '0;
            rem_q       <= '0;
            shreg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        divisor_q   <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else if (too_big) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            overflow    <= 1'b1;
                        end else begin
                            rem_q <= hi;
                            shreg <= dividend[Q-1:0];
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    shreg <= shift_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        quotient  <= shift_next;
                        remainder <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sabr_udiv_seq.sv
// tb_sabr_udiv_seq: directed and randomized checks of sabr_udiv_seq against
// a wide-arithmetic reference model.
module tb_sabr_udiv_seq;
    localparam int N = 79;
    localparam int D = 36;
    localparam int Q = 43;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ce = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [Q-1:0] quotient;
    logic [D-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    sabr_udiv_seq #(
        .ID(1),
        .DIVIDEND_WIDTH(N),
        .DIVISOR_WIDTH(D),
        .QUOTIENT_WIDTH(Q)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain wide division plus the exception rules.
    function automatic void model(input logic [N-1:0] a, input logic [D-1:0] d,
                                  output logic [Q-1:0] q, output logic [D-1:0] r,
                                  output bit dz, output bit ov);
        logic [N-1:0] dd, qf, rf, lim;
        dz = 0; ov = 0; q = '0; r = '0;
        if (d == '0) begin
            dz = 1; q = '1; r = '0;
        end else begin
            dd = '0; dd[D-1:0] = d;
            qf = a / dd;
            rf = a % dd;
            lim = '0; lim[Q] = 1'b1;
            if (qf >= lim) begin
                ov = 1; q = '1; r = '0;
            end else begin
                q = qf[Q-1:0];
                r = rf[D-1:0];
            end
        end
    endfunction

    // Presents operands until accepted, then waits for out_valid.
    // ce_mode: 0 = ce high, 1 = ce toggles starting low after accept, 2 = random ce.
    task automatic run_div(input logic [N-1:0] a, input logic [D-1:0] d, input int ce_mode,
                           output int en_edges, output int cycles, output bit timed_out);
        int guard;
        bit acc;
        timed_out = 0; en_edges = 0; cycles = 0; guard = 0;
        dividend = a; divisor = d; in_valid = 1'b1;
        do begin
            ce = (ce_mode == 2) ? (($urandom % 4) != 0) : 1'b1;
            acc = (in_ready === 1'b1) && (ce === 1'b1);
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 200);
        in_valid = 1'b0;
        if (!acc) begin
            timed_out = 1; ce = 1'b1;
            return;
        end
        while (out_valid !== 1'b1 && cycles < 1000) begin
            case (ce_mode)
                1:       ce = ((cycles % 2) == 1);
                2:       ce = (($urandom % 4) != 0);
                default: ce = 1'b1;
            endcase
            @(posedge clk); #1;
            cycles++;
            if (ce) en_edges++;
        end
        if (out_valid !== 1'b1) timed_out = 1;
        ce = 1'b1;
    endtask

    task automatic consume(input bit rand_rdy, output bit timed_out);
        int guard;
        bit done;
        guard = 0; done = 0;
        do begin
            ce        = rand_rdy ? (($urandom % 4) != 0) : 1'b1;
            out_ready = rand_rdy ? (($urandom % 2) != 0) : 1'b1;
            done = ce && out_ready;
            @(posedge clk); #1;
            guard++;
        end while (!done && guard < 200);
        out_ready = 1'b0; ce = 1'b1;
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("FAIL reset_data q=%0d r=%0d exp=0/0", quotient, remainder); end
        checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags dz=%b ov=%b exp=0/0", div_by_zero, overflow); end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int en, cyc; bit to;
        run_div(N'(100), D'(7), 0, en, cyc, to);
        checks++; if (to || en != Q) begin errors++; $display("FAIL basic_latency got=%0d timeout=%0b exp=%0d", en, to, Q); end
        checks++; if (quotient !== Q'(14) || remainder !== D'(2)) begin errors++; $display("FAIL basic_result q=%0d r=%0d exp=14/2", quotient, remainder); end
        checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL basic_flags dz=%b ov=%b exp=0/0", div_by_zero, overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy in_ready=%b exp=0", in_ready); end
        consume(0, to);
        checks++; if (to || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_max_quotient();
        int en, cyc; bit to;
        logic [N-1:0] a;
        logic [D-1:0] d;
        logic [Q-1:0] qe;
        d = '1;
        a = '0; a[N-1:Q] = d; a = a - N'(1);
        qe = '1;
        run_div(a, d, 0, en, cyc, to);
        checks++; if (to || quotient !== qe) begin errors++; $display("FAIL maxq_quotient got=%0h exp=%0h", quotient, qe); end
        checks++; if (remainder !== (d - D'(1))) begin errors++; $display("FAIL maxq_remainder got=%0h exp=%0h", remainder, d - D'(1)); end
        checks++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL maxq_flags dz=%b ov=%b exp=0/0", div_by_zero, overflow); end
        consume(0, to);
    endtask

    task automatic test_exceptions();
        int en, cyc; bit to;
        logic [N-1:0] a;
        logic [Q-1:0] ones;
        ones = '1;
        run_div(N'(5), '0, 0, en, cyc, to);
        checks++; if (to || en > 1) begin errors++; $display("FAIL dz_latency got=%0d timeout=%0b exp<=1", en, to); end
        checks++; if (div_by_zero !== 1'b1 || overflow !== 1'b0 || quotient !== ones || remainder !== '0)
            begin errors++; $display("FAIL dz_result dz=%b ov=%b q=%0h r=%0h exp=1/0/all-ones/0", div_by_zero, overflow, quotient, remainder); end
        consume(0, to);
        a = '0; a[Q+1:Q] = 2'b11;
        run_div(a, D'(3), 0, en, cyc, to);
        checks++; if (to || en > 1) begin errors++; $display("FAIL ov_latency got=%0d timeout=%0b exp<=1", en, to); end
        checks++; if (overflow !== 1'b1 || div_by_zero !== 1'b0 || quotient !== ones || remainder !== '0)
            begin errors++; $display("FAIL ov_result dz=%b ov=%b q=%0h r=%0h exp=0/1/all-ones/0", div_by_zero, overflow, quotient, remainder); end
        consume(0, to);
    endtask

    task automatic test_stall_backpressure();
        int en, cyc; bit to;
        // ce low must block an accept even with in_valid high
        dividend = N'(1000); divisor = D'(10); in_valid = 1'b1; ce = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ce_hold_idle in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        ce = 1'b1;
        run_div(N'(1000), D'(10), 1, en, cyc, to);
        checks++; if (to || cyc != 2 * Q) begin errors++; $display("FAIL stall_cycles got=%0d exp=%0d", cyc, 2 * Q); end
        checks++; if (quotient !== Q'(100) || remainder !== '0) begin errors++; $display("FAIL stall_result q=%0d r=%0d exp=100/0", quotient, remainder); end
        dividend = N'(77); divisor = D'(7); in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== Q'(100) || remainder !== '0)
                begin errors++; $display("FAIL backpressure_hold cyc=%0d ov=%b ir=%b q=%0d r=%0d exp=1/0/100/0", i, out_valid, in_ready, quotient, remainder); end
        end
        in_valid = 1'b0;
        consume(0, to);
        checks++; if (to || in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== Q'(100))
            begin errors++; $display("FAIL backpressure_release ir=%b ov=%b q=%0d exp=1/0/100", in_ready, out_valid, quotient); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stay_idle ov=%b ir=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int en, cyc; bit to;
        dividend = N'(1000); divisor = D'(10); in_valid = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_busy ir=%b ov=%b exp=0/0", in_ready, out_valid); end
        #3 reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0)
            begin errors++; $display("FAIL mid_reset ir=%b ov=%b q=%0d r=%0d exp=1/0/0/0", in_ready, out_valid, quotient, remainder); end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_div(N'(81), D'(9), 0, en, cyc, to);
        checks++; if (to || quotient !== Q'(9) || remainder !== '0 || en != Q)
            begin errors++; $display("FAIL after_reset q=%0d r=%0d lat=%0d exp=9/0/%0d", quotient, remainder, en, Q); end
        consume(0, to);
    endtask

    task automatic test_random(input int count);
        int en, cyc, sel; bit to, dz, ov;
        logic [95:0] r96;
        logic [63:0] r64;
        logic [N-1:0] a, lim;
        logic [D-1:0] d, re;
        logic [Q-1:0] qe;
        logic [N:0] qx, dx, rx, ax;
        for (int i = 0; i < count; i++) begin
            sel = $urandom % 8;
            r96 = {$urandom, $urandom, $urandom};
            r64 = {$urandom, $urandom};
            a = r96[N-1:0];
            d = r64[D-1:0] >> ($urandom % D);
            if (sel == 0) d = '0;
            if (sel >= 2 && d != '0) begin
                lim = '0; lim[N-1:Q] = d;
                a = a % lim;
            end
            model(a, d, qe, re, dz, ov);
            run_div(a, d, 2, en, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout op=%0d a=%0h d=%0h", i, a, d); end
            checks++; if (quotient !== qe || remainder !== re)
                begin errors++; $display("FAIL rand_result op=%0d a=%0h d=%0h q=%0h r=%0h exp=%0h/%0h", i, a, d, quotient, remainder, qe, re); end
            checks++; if (div_by_zero !== dz || overflow !== ov)
                begin errors++; $display("FAIL rand_flags op=%0d dz=%b ov=%b exp=%b/%b", i, div_by_zero, overflow, dz, ov); end
            if (!dz && !ov) begin
                qx = '0; qx[Q-1:0] = quotient;
                dx = '0; dx[D-1:0] = d;
                rx = '0; rx[D-1:0] = remainder;
                ax = '0; ax[N-1:0] = a;
                checks++; if (qx * dx + rx !== ax || remainder >= d)
                    begin errors++; $display("FAIL rand_contract op=%0d a=%0h d=%0h q=%0h r=%0h", i, a, d, quotient, remainder); end
                checks++; if (en != Q) begin errors++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", i, en, Q); end
            end
            consume(1, to);
            checks++; if (to) begin errors++; $display("FAIL rand_consume_timeout op=%0d", i); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_quotient();
        test_exceptions();
        test_stall_backpressure();
        test_reset_mid();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
